// File: rtl/scan_display_mux.sv
// scan_display_mux: multiplexed 7-segment scanner, double-buffered digit data.
// Define SCAN_LZ_BLANK_EN to enable leading-zero suppression.
module scan_display_mux #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int GA_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     ga,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic DP_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] GA_INV = {DIGITS{GA_ACTIVE_LOW != 0}};

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic                 run;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic                 slot_end;
  logic                 boundary;
  logic [4*DIGITS-1:0]  pend_data;
  logic [DIGITS-1:0]    pend_dp;
  logic [DIGITS-1:0]    pend_blank;
  logic                 pend_valid;
  logic [4*DIGITS-1:0]  act_data;
  logic [DIGITS-1:0]    act_dp;
  logic [DIGITS-1:0]    act_blank;
  logic                 act_valid;

  assign slot_end = run && (cnt == CNT_MAX);
  assign boundary = slot_end && (idx == IDX_MAX);

  // run holds the prescaler at 0 for the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      run <= 1'b1;
      if (slot_end) begin
        cnt <= '0;
        idx <= boundary ? '0 : idx + 1'b1;
      end else if (run) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_valid  <= 1'b0;
    end else begin
      if (load && !boundary) begin
        pend_data  <= data;
        pend_dp    <= dp;
        pend_blank <= blank;
        pend_valid <= 1'b1;
      end
      if (boundary) begin
        unique case (1'b1)
          load: begin
            act_data   <= data;
            act_dp     <= dp;
            act_blank  <= blank;
            act_valid  <= 1'b1;
            pend_valid <= 1'b0;
          end
          pend_valid: begin
            act_data   <= pend_data;
            act_dp     <= pend_dp;
            act_blank  <= pend_blank;
            act_valid  <= 1'b1;
            pend_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  logic [DIGITS-1:0] lz;

`ifdef SCAN_LZ_BLANK_EN
  always_comb begin
    logic still;
    lz    = '0;
    still = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (still && act_data[4*i +: 4] == 4'h0 && !act_dp[i])
        lz[i] = 1'b1;
      else
        still = 1'b0;
    end
  end
`else
  assign lz = '0;
`endif

  logic [3:0]        nib;
  logic              in_guard;
  logic              lit;
  logic              dark;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] ga_n;

  always_comb begin
    nib      = act_data[4*idx +: 4];
    in_guard = int'(cnt) < GUARD;
    lit      = act_valid && !in_guard;
    dark     = act_blank[idx] | lz[idx];
    ga_n     = '0;
    seg_n    = '0;
    dp_n     = 1'b0;
    if (lit) begin
      ga_n[idx] = 1'b1;
      if (!dark) begin
        seg_n = hex7(nib);
        dp_n  = act_dp[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_INV;
      dp_out     <= DP_INV;
      ga         <= GA_INV;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_n ^ SEG_INV;
      dp_out     <= dp_n ^ DP_INV;
      ga         <= ga_n ^ GA_INV;
      frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_scan_display_mux.sv
// tb_scan_display_mux: frame-level scoreboard for scan_display_mux.
module tb_scan_display_mux;

  localparam int G = 1;

  localparam logic [6:0] DEC [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp_out;
  logic [3:0]  ga;
  logic        frame_tick;

  int total = 0;
  int bad = 0;
  logic [12:0] exp_q [$];

  always #5 clk = ~clk;

  scan_display_mux #(
    .DIGITS(4),
    .SCAN_DIV(4),
    .GUARD(G),
    .SEG_ACTIVE_LOW(1),
    .GA_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .dp(dp),
    .blank(blank),
    .load(load),
    .seg(seg),
    .dp_out(dp_out),
    .ga(ga),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] obs();
    return {frame_tick, ga, seg, dp_out};
  endfunction

  // expected {tick,ga,seg,dp_out} for the 16 samples after a frame_tick
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p,
                            input logic [3:0] b, input bit v);
    logic [3:0] lz;
    bit still;
    lz = '0;
    still = 1'b1;
`ifdef SCAN_LZ_BLANK_EN
    for (int i = 3; i >= 1; i--) begin
      if (still && d[i*4 +: 4] == 4'h0 && !p[i]) lz[i] = 1'b1;
      else still = 1'b0;
    end
`endif
    for (int j = 1; j <= 16; j++) begin
      int c;
      int x;
      logic [3:0] g;
      logic [6:0] s;
      logic o;
      c = (j - 1) % 4;
      x = (j - 1) / 4;
      g = 4'hF;
      s = 7'h7F;
      o = 1'b1;
      if (v && c >= G) begin
        g = ~(4'b0001 << x);
        if (!(b[x] || lz[x])) begin
          s = ~DEC[d[x*4 +: 4]];
          o = ~p[x];
        end
      end
      exp_q.push_back({(j == 16), g, s, o});
    end
  endtask

  task automatic run_frame(input string tag,
                           input int k1, input logic [15:0] d1,
                           input logic [3:0] p1, input logic [3:0] b1,
                           input int k2, input logic [15:0] d2,
                           input logic [3:0] p2, input logic [3:0] b2);
    logic [12:0] e;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 13'bx;
      chk(tag, 32'(obs()), 32'(e));
      load = 1'b0;
      if (j == k1) begin
        data = d1; dp = p1; blank = b1; load = 1'b1;
      end
      if (j == k2) begin
        data = d2; dp = p2; blank = b2; load = 1'b1;
      end
    end
  endtask

  task automatic sync_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 60);
    chk("sync", 32'(frame_tick), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(obs()), 32'({1'b0, 4'hF, 7'h7F, 1'b1}));
    rst_n = 1'b1;
    sync_tick();

    push_frame(16'h0, 4'h0, 4'h0, 1'b0);
    run_frame("dark", 5, 16'h1234, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    push_frame(16'h1234, 4'h0, 4'h0, 1'b1);
    run_frame("f1234", 5, 16'hABCD, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    push_frame(16'hABCD, 4'h0, 4'h0, 1'b1);
    run_frame("fabcd", 15, 16'h000F, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    push_frame(16'h000F, 4'h0, 4'h0, 1'b1);
    run_frame("f000f", 15, 16'h1234, 4'b0001, 4'b0010,
              -1, 16'h0, 4'h0, 4'h0);

    push_frame(16'h1234, 4'b0001, 4'b0010, 1'b1);
    run_frame("fblank", 3, 16'h9999, 4'hF, 4'h0,
              9, 16'h0050, 4'h0, 4'h0);

    push_frame(16'h0050, 4'h0, 4'h0, 1'b1);
    run_frame("f0050", -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    // a pending load followed by a mid-frame reset must be discarded
    repeat (3) @(negedge clk);
    data = 16'h7777;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", 32'(obs()), 32'({1'b0, 4'hF, 7'h7F, 1'b1}));
    rst_n = 1'b1;
    sync_tick();

    push_frame(16'h0, 4'h0, 4'h0, 1'b0);
    run_frame("rdark", -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    push_frame(16'h0, 4'h0, 4'h0, 1'b0);
    run_frame("rdark2", 4, 16'h4321, 4'b0100, 4'h0,
              -1, 16'h0, 4'h0, 4'h0);

    push_frame(16'h4321, 4'b0100, 4'h0, 1'b1);
    run_frame("f4321", -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
